// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO consumer: packer FSM states and
// small elaboration helpers for counter width and byte-keep masks.
package fifo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Mask with the low cnt lanes set; callers truncate to their lane count.
    function automatic logic [31:0] keep_mask(input int unsigned cnt);
        return (32'd1 << cnt) - 32'd1;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port, flush request and packed output stream.
// The packer is the slave; the FIFO/downstream environment is the master.
interface fifo_rd_packer_if #(
    parameter int DATA_SIZE  = 8,
    parameter int WORD_BYTES = 4
);
    logic                              fifo_empty;
    logic [DATA_SIZE-1:0]              fifo_rd_data;
    logic                              fifo_rd_en;
    logic                              flush;
    logic                              out_valid;
    logic                              out_ready;
    logic [DATA_SIZE*WORD_BYTES-1:0]   out_data;
    logic [WORD_BYTES-1:0]             out_keep;

    modport master (
        output fifo_empty, fifo_rd_data, flush, out_ready,
        input  fifo_rd_en, out_valid, out_data, out_keep
    );

    modport slave (
        input  fifo_empty, fifo_rd_data, flush, out_ready,
        output fifo_rd_en, out_valid, out_data, out_keep
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries, packs WORD_BYTES of them little-endian into one output
// word on a valid/ready stream; a flush emits the partial tail with a keep mask.
//
// state | meaning
// RUN   | popping entries into the accumulator, full words go to the output
// FLUSH | waiting for a free output register to emit the partial word
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_packer_if.slave  bus
);
    localparam int CW = clog2(WORD_BYTES);
    localparam int WW = DATA_SIZE * WORD_BYTES;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [DATA_SIZE-1:0]    r_acc [WORD_BYTES];
    logic                    r_out_valid;
    logic [WW-1:0]           r_out_data;
    logic [WORD_BYTES-1:0]   r_out_keep;

    logic                    w_drain;
    logic                    w_out_free;
    logic                    w_last;
    logic                    w_pop;
    logic [WW-1:0]           w_full_word;
    logic [WW-1:0]           w_part_word;
    logic [WORD_BYTES-1:0]   w_part_keep;

    assign w_drain     = r_out_valid & bus.out_ready;
    assign w_out_free  = ~r_out_valid | w_drain;
    assign w_last      = (r_cnt == CW'(WORD_BYTES - 1));
    assign w_part_keep = WORD_BYTES'(keep_mask(32'(r_cnt)));

    // The last lane only needs the output register; earlier lanes fill the accumulator freely.
    assign w_pop = ~rst & (r_state == RUN) & ~bus.fifo_empty & ~bus.flush
                 & (~w_last | w_out_free);

    assign bus.fifo_rd_en = w_pop;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_keep   = r_out_keep;

    always_comb begin
        w_full_word = '0;
        w_part_word = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (i == WORD_BYTES - 1)
                w_full_word[i*DATA_SIZE +: DATA_SIZE] = bus.fifo_rd_data;
            else
                w_full_word[i*DATA_SIZE +: DATA_SIZE] = r_acc[i];
            if (w_part_keep[i])
                w_part_word[i*DATA_SIZE +: DATA_SIZE] = r_acc[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            for (int i = 0; i < WORD_BYTES; i++) r_acc[i] <= '0;
        end else begin
            if (w_drain) r_out_valid <= 1'b0;

            case (r_state)
                RUN: begin
                    if (bus.flush) begin
                        r_state <= FLUSH;
                    end else if (w_pop) begin
                        r_acc[r_cnt] <= bus.fifo_rd_data;
                        if (w_last) begin
                            r_out_data  <= w_full_word;
                            r_out_keep  <= '1;
                            r_out_valid <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (r_cnt == '0) begin
                        r_state <= RUN;
                    end else if (w_out_free) begin
                        r_out_data  <= w_part_word;
                        r_out_keep  <= w_part_keep;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, running entirely in the read clock domain. It pops DATA_SIZE-bit entries from the FIFO read port whenever the FIFO is non-empty and buffer space allows. It packs WORD_BYTES consecutive entries little-endian into one output word and presents that word on a valid/ready stream. A flush request emits a partial word with a byte-keep mask, so the tail of a transfer is never stranded.

## Interface
Parameters:
- DATA_SIZE, 8: width of one FIFO entry (one lane).
- WORD_BYTES, 4: lanes per output word; ≥2, power of two.

Ports:
- clk  in  1  read-domain clock; the same clock as the FIFO read side.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  FIFO empty flag, registered in the FIFO.
- fifo_rd_data  in  DATA_SIZE  FIFO read data. Combinational from the FIFO; valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to the FIFO; combinational.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  output word valid; registered.
- out_ready  in  1  downstream accepts the word when out_valid & out_ready.
- out_data  out  DATA_SIZE*WORD_BYTES  packed word; lane 0 is the oldest entry, in bits [DATA_SIZE-1:0].
- out_keep  out  WORD_BYTES  per-lane valid mask; all ones for a full word.

## Operation
Storage:
- Accumulator acc[WORD_BYTES-1:0][DATA_SIZE-1:0].
- Lane counter cnt, width log2(WORD_BYTES).
- Output register holding out_data, out_keep and out_valid.

Terms:
- pop = fifo_rd_en.
- drain = out_valid & out_ready.
- out_free = !out_valid | drain.

State machine:
- RUN:
  - fifo_rd_en = !fifo_empty & !flush & (cnt != WORD_BYTES-1 | out_free).
  - On pop: acc[cnt] <= fifo_rd_data and cnt increments.
  - On pop with cnt = WORD_BYTES-1:
    - The word {fifo_rd_data, acc[WORD_BYTES-2:0]} loads the output register with out_keep all ones.
    - cnt wraps to 0.
  - On flush: go to FLUSH. No pop occurs in the flush cycle.
- FLUSH:
  - fifo_rd_en = 0.
  - If cnt = 0: return to RUN next cycle; no word is emitted.
  - Else, when out_free:
    - Load the output register with acc.
    - out_keep = (1<<cnt)-1.
    - Unfilled lanes are driven to zero.
    - cnt <= 0; return to RUN.
  - Otherwise wait in FLUSH.
  - A flush asserted while already in FLUSH is ignored.

Output register rules:
- Loaded only when out_free.
- After drain with no new load, out_valid <= 0.
- out_data and out_keep are held stable while out_valid=1 and out_ready=0.

Other rules:
- fifo_rd_en is never asserted while fifo_empty=1, so the FIFO pointer never over-reads.
- Reset values: state=RUN, cnt=0, acc=0, out_valid=0, out_data=0, out_keep=0.
- fifo_rd_en=0 while rst is high.
- A reset mid-word discards the accumulated lanes; no partial word is emitted.

## Timing
- Pop and capture occur in the same cycle: fifo_rd_data is sampled on the edge where fifo_rd_en=1. The FIFO's empty flag already reflects that pop on the following cycle.
- Latency: out_valid rises on the edge after the final lane's pop. With 4 pops in cycles 0-3, out_valid=1 in cycle 4.
- Throughput: 1 entry per clk sustained while out_ready=1, with no bubble at word boundaries.
- Backpressure: with out_valid=1 and out_ready=0, popping continues until cnt = WORD_BYTES-1, then stalls. At most WORD_BYTES-1 entries are buffered beyond the output register.
- fifo_rd_en depends combinationally on out_ready and flush. Downstream must not derive out_ready from fifo_rd_en.
- Flush latency: partial out_valid appears 2 cycles after the flush pulse when the output register is free.

## Structure
- Shared package fifo_pkg holds:
  - Function clog2, used for the cnt width.
  - Function keep_mask(cnt) returning (1<<cnt)-1.
  - State enum {RUN, FLUSH}.
- Single module; no sub-module is warranted. Accumulator, counter, FSM and output register are ≈150 lines.

## Test plan
- Stream: FIFO holds 8 entries 0x11..0x88, out_ready=1 → two words: 0x44332211 then 0x88776655, keep=0xF, out_valid in cycles 4 and 8, fifo_rd_en high for 8 consecutive cycles.
- Backpressure: 9 entries queued, out_ready=0 → one word held stable, 3 further pops, then fifo_rd_en=0. Raising out_ready resumes with no loss or reorder.
- Flush: 3 entries 0xA1,0xA2,0xA3 then flush → out_data=0x00A3A2A1, keep=0x7. A flush with cnt=0 produces no output.
- Flush blocked: flush while a full word is held with out_ready=0 → state stays FLUSH and no pops occur. The partial word follows immediately after the first word drains.
- Empty gating: fifo_empty toggling randomly with out_ready=1 → fifo_rd_en never high when fifo_empty=1, and the byte order is preserved.
- Reset mid-word: rst asserted after 2 pops → outputs zero; the next 4 entries form a clean word with keep=0xF.
